// File: rtl/vblank_mem_arbiter_pkg.sv
// Shared types and constants for the vertical-blank memory arbiter.
// VBLANK_START is the same line that opens the VGAController load window.
package vblank_mem_arbiter_pkg;

  localparam int unsigned VBLANK_START = 32'd511;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_VGA = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    CPU_OWN  = 2'd0,
    VGA_OWN  = 2'd1,
    CPU_SLOT = 2'd2
  } arb_state_e;

  // Counter width that stays legal (at least one bit) for a burst limit of 1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/vblank_mem_arbiter_mem_return_router.sv
// Remembers who issued each memory read and steers the 1-cycle-late
// mem_rdata to the CPU or VGA return port; writes produce no return.
module mem_return_router
  import vblank_mem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue_read,
  input  owner_e                issue_owner,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] vga_rdata,
  output logic                  vga_rvalid
);

  logic                  cpu_rvalid_q, cpu_rvalid_d;
  logic                  vga_rvalid_q, vga_rvalid_d;
  logic [DATA_WIDTH-1:0] cpu_hold_q, cpu_hold_d;
  logic [DATA_WIDTH-1:0] vga_hold_q, vga_hold_d;

  // Tag the issued read and keep the last returned word per owner.
  always_comb begin
    cpu_rvalid_d = issue_read && (issue_owner == OWN_CPU);
    vga_rvalid_d = issue_read && (issue_owner == OWN_VGA);
    cpu_hold_d   = cpu_rvalid_q ? mem_rdata : cpu_hold_q;
    vga_hold_d   = vga_rvalid_q ? mem_rdata : vga_hold_q;
  end

  // Tag and held-data registers; reset drops any read still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_rvalid_q <= 1'b0;
      vga_rvalid_q <= 1'b0;
      cpu_hold_q   <= '0;
      vga_hold_q   <= '0;
    end else begin
      cpu_rvalid_q <= cpu_rvalid_d;
      vga_rvalid_q <= vga_rvalid_d;
      cpu_hold_q   <= cpu_hold_d;
      vga_hold_q   <= vga_hold_d;
    end
  end

  // The memory already registers its output, so the return cycle forwards it.
  always_comb begin
    cpu_rvalid = cpu_rvalid_q;
    vga_rvalid = vga_rvalid_q;
    cpu_rdata  = cpu_rvalid_q ? mem_rdata : cpu_hold_q;
    vga_rdata  = vga_rvalid_q ? mem_rdata : vga_hold_q;
  end

endmodule

// File: rtl/vblank_mem_arbiter.sv
// Shares one synchronous memory port between the CPU and the VGA frame
// loader: CPU during active video, bounded VGA bursts during vertical blank.
module vblank_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned VBLANK_START = vblank_mem_arbiter_pkg::VBLANK_START,
  parameter int unsigned MAX_BURST    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [9:0]            v_count,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_stall,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_rvalid,
  input  logic                  vga_req,
  input  logic [ADDR_WIDTH-1:0] vga_addr,
  output logic                  vga_grant,
  output logic [DATA_WIDTH-1:0] vga_rdata,
  output logic                  vga_rvalid,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  in_vblank
);

  import vblank_mem_arbiter_pkg::*;

  localparam int unsigned     CNT_W      = cnt_width(MAX_BURST);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 32'd1);
  localparam logic [9:0]      VB_LINE    = 10'(VBLANK_START);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             in_vblank_q, in_vblank_d;
  logic             issue_read;
  owner_e           issue_owner;

  // State, burst counter and blanking flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= CPU_OWN;
      burst_cnt_q <= '0;
      in_vblank_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      in_vblank_q <= in_vblank_d;
    end
  end

  // Next state; the counter only survives while staying in VGA_OWN.
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = '0;
    in_vblank_d = (v_count >= VB_LINE);
    case (state_q)
      CPU_OWN: begin
        if (in_vblank_q && vga_req) begin
          state_d = VGA_OWN;
        end else begin
          state_d = CPU_OWN;
        end
      end
      VGA_OWN: begin
        // Leaving blanking or an idle loader outranks the fairness slot.
        if (!vga_req || !in_vblank_q) begin
          state_d = CPU_OWN;
        end else if ((burst_cnt_q == BURST_LAST) && cpu_req) begin
          state_d = CPU_SLOT;
        end else begin
          state_d     = VGA_OWN;
          burst_cnt_d = (burst_cnt_q == BURST_LAST) ? burst_cnt_q
                                                    : burst_cnt_q + CNT_W'(1);
        end
      end
      CPU_SLOT: begin
        if (in_vblank_q && vga_req) begin
          state_d = VGA_OWN;
        end else begin
          state_d = CPU_OWN;
        end
      end
      default: begin
        state_d = CPU_OWN;
      end
    endcase
  end

  // Port mux; the VGA side can never write, and nothing issues during reset.
  always_comb begin
    vga_grant   = 1'b0;
    cpu_stall   = 1'b0;
    mem_addr    = cpu_addr;
    mem_we      = 1'b0;
    mem_wdata   = cpu_wdata;
    issue_read  = 1'b0;
    issue_owner = OWN_CPU;
    if (reset) begin
      cpu_stall = cpu_req;
      mem_addr  = '0;
      mem_wdata = '0;
    end else begin
      case (state_q)
        VGA_OWN: begin
          vga_grant   = vga_req;
          cpu_stall   = cpu_req;
          mem_addr    = vga_addr;
          mem_wdata   = '0;
          issue_read  = vga_req;
          issue_owner = OWN_VGA;
        end
        CPU_OWN, CPU_SLOT: begin
          mem_we     = cpu_req && cpu_we;
          issue_read = cpu_req && !cpu_we;
        end
        default: begin
          cpu_stall = cpu_req;
          mem_addr  = '0;
          mem_wdata = '0;
        end
      endcase
    end
  end

  assign in_vblank = in_vblank_q;

  mem_return_router #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_return_router (
    .clk         (clk),
    .reset       (reset),
    .issue_read  (issue_read),
    .issue_owner (issue_owner),
    .mem_rdata   (mem_rdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_rvalid  (cpu_rvalid),
    .vga_rdata   (vga_rdata),
    .vga_rvalid  (vga_rvalid)
  );

endmodule

// File: tb/tb_vblank_mem_arbiter.sv
// Bench for vblank_mem_arbiter: directed vector table, a reset-mid-burst
// sequence, then random traffic against a transaction-level reference model.
module tb_vblank_mem_arbiter;

  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  v_count;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr, cpu_wdata;
  logic        cpu_stall, cpu_rvalid;
  logic [15:0] cpu_rdata;
  logic        vga_req;
  logic [15:0] vga_addr;
  logic        vga_grant, vga_rvalid;
  logic [15:0] vga_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic        in_vblank;

  always #5 clk = ~clk;

  vblank_mem_arbiter #(
    .ADDR_WIDTH(16), .DATA_WIDTH(16), .VBLANK_START(511), .MAX_BURST(MAXB)
  ) dut (
    .clk(clk), .reset(reset), .v_count(v_count),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_grant(vga_grant),
    .vga_rdata(vga_rdata), .vga_rvalid(vga_rvalid),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .in_vblank(in_vblank)
  );

  // Synchronous RAM with 1-cycle read latency; unwritten words read a hash.
  logic [15:0] mem_arr [65536];
  bit          mem_vld [65536];

  function automatic logic [15:0] mem_read(input logic [15:0] a);
    return mem_vld[a] ? mem_arr[a] : (a ^ 16'hA5A5);
  endfunction

  always @(posedge clk) begin
    mem_rdata <= mem_read(mem_addr);
    if (mem_we) begin
      mem_arr[mem_addr] <= mem_wdata;
      mem_vld[mem_addr] <= 1'b1;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: who holds the port, length of the current VGA run,
  // and the read expected back next cycle.
  bit          m_vb, m_vga, m_slot, m_stall;
  int          m_run;
  bit          m_pc, m_pv;
  logic [15:0] m_pd;

  task automatic model_clear();
    m_vb = 0; m_vga = 0; m_slot = 0; m_run = 0; m_pc = 0; m_pv = 0; m_pd = '0; m_stall = 0;
  endtask

  // Check one cycle (inputs already driven after a negedge), advance model.
  task automatic run_cycle(input string tag);
    bit          e_grant, e_stall, e_we, cpu_rd, vga_rd;
    logic [15:0] e_addr, e_wd;
    #1;
    if (reset) begin
      e_grant = 0; e_stall = cpu_req; e_we = 0; e_addr = '0; e_wd = '0;
    end else if (m_vga) begin
      e_grant = vga_req; e_stall = cpu_req; e_we = 0; e_addr = vga_addr; e_wd = '0;
    end else begin
      e_grant = 0; e_stall = 0; e_we = cpu_req && cpu_we; e_addr = cpu_addr; e_wd = cpu_wdata;
    end
    chk({tag, ".grant"}, vga_grant, e_grant);
    chk({tag, ".stall"}, cpu_stall, e_stall);
    chk({tag, ".mem_we"}, mem_we, e_we);
    chk({tag, ".mem_addr"}, mem_addr, e_addr);
    if (e_we) chk({tag, ".mem_wdata"}, mem_wdata, e_wd);
    chk({tag, ".in_vblank"}, in_vblank, m_vb);
    chk({tag, ".cpu_rvalid"}, cpu_rvalid, m_pc);
    chk({tag, ".vga_rvalid"}, vga_rvalid, m_pv);
    if (m_pc) chk({tag, ".cpu_rdata"}, cpu_rdata, m_pd);
    if (m_pv) chk({tag, ".vga_rdata"}, vga_rdata, m_pd);

    cpu_rd = !reset && !m_vga && cpu_req && !cpu_we;
    vga_rd = !reset && m_vga && vga_req;
    m_pc = cpu_rd;
    m_pv = vga_rd;
    m_pd = mem_read(e_addr);
    m_stall = e_stall;
    if (reset) begin
      m_vga = 0; m_slot = 0; m_run = 0;
    end else if (m_slot) begin
      m_slot = 0; m_run = 0; m_vga = m_vb && vga_req;
    end else if (m_vga) begin
      if (!vga_req || !m_vb) begin
        m_vga = 0; m_run = 0;
      end else if (m_run >= MAXB - 1 && cpu_req) begin
        m_vga = 0; m_slot = 1; m_run = 0;
      end else begin
        m_run++;
      end
    end else begin
      m_vga = m_vb && vga_req; m_run = 0;
    end
    m_vb = !reset && (v_count >= 10'd511);
    @(negedge clk);
  endtask

  typedef struct {
    bit          rst;
    logic [9:0]  vc;
    bit          creq, cwe;
    logic [15:0] caddr;
    bit          vreq;
    logic [15:0] vaddr;
    bit          x_grant, x_stall, x_we;
    logic [15:0] x_addr;
    bit          x_crv, x_vrv;
  } vec_t;

  vec_t tbl [18];

  initial begin
    reset = 1; v_count = '0; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    vga_req = 0; vga_addr = '0;
    repeat (2) @(negedge clk);
    model_clear();

    //         rst vc       creq we caddr      vreq vaddr     gnt stl we addr      crv vrv
    tbl[0]  = '{0, 10'd100, 1, 0, 16'h0F0F, 0, 16'h0000, 0, 0, 0, 16'h0F0F, 0, 0};
    tbl[1]  = '{0, 10'd100, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 0};
    tbl[2]  = '{0, 10'd511, 0, 0, 16'h0000, 1, 16'h0FF0, 0, 0, 0, 16'h0000, 0, 0};
    tbl[3]  = '{0, 10'd511, 1, 0, 16'h1234, 1, 16'h0FF1, 0, 0, 0, 16'h1234, 0, 0};
    tbl[4]  = '{0, 10'd511, 0, 0, 16'h0000, 1, 16'h0FF2, 1, 0, 0, 16'h0FF2, 1, 0};
    tbl[5]  = '{0, 10'd511, 0, 0, 16'h0000, 1, 16'h0FF3, 1, 0, 0, 16'h0FF3, 0, 1};
    tbl[6]  = '{0, 10'd511, 1, 1, 16'h2222, 1, 16'h0FF4, 1, 1, 0, 16'h0FF4, 0, 1};
    tbl[7]  = '{0, 10'd511, 1, 1, 16'h2222, 1, 16'h0FF5, 1, 1, 0, 16'h0FF5, 0, 1};
    tbl[8]  = '{0, 10'd511, 1, 1, 16'h2222, 1, 16'h0FF6, 0, 0, 1, 16'h2222, 0, 1};
    tbl[9]  = '{0, 10'd511, 1, 0, 16'h3333, 1, 16'h0FF6, 1, 1, 0, 16'h0FF6, 0, 0};
    tbl[10] = '{0, 10'd524, 1, 0, 16'h3333, 1, 16'h0FF7, 1, 1, 0, 16'h0FF7, 0, 1};
    tbl[11] = '{0, 10'd0,   1, 0, 16'h3333, 1, 16'h0FF8, 1, 1, 0, 16'h0FF8, 0, 1};
    tbl[12] = '{0, 10'd1,   1, 0, 16'h3333, 1, 16'h0FF9, 1, 1, 0, 16'h0FF9, 0, 1};
    tbl[13] = '{0, 10'd2,   1, 0, 16'h3333, 1, 16'h0FFA, 0, 0, 0, 16'h3333, 0, 1};
    tbl[14] = '{0, 10'd3,   0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 0};
    tbl[15] = '{0, 10'd520, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0};
    tbl[16] = '{0, 10'd520, 1, 0, 16'h5555, 0, 16'h0000, 0, 0, 0, 16'h5555, 0, 0};
    tbl[17] = '{0, 10'd520, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 0};

    for (int i = 0; i < 18; i++) begin
      reset = tbl[i].rst; v_count = tbl[i].vc;
      cpu_req = tbl[i].creq; cpu_we = tbl[i].cwe; cpu_addr = tbl[i].caddr;
      cpu_wdata = tbl[i].caddr + 16'd1;
      vga_req = tbl[i].vreq; vga_addr = tbl[i].vaddr;
      #1;
      chk($sformatf("vec%0d.grant", i), vga_grant, tbl[i].x_grant);
      chk($sformatf("vec%0d.stall", i), cpu_stall, tbl[i].x_stall);
      chk($sformatf("vec%0d.mem_we", i), mem_we, tbl[i].x_we);
      chk($sformatf("vec%0d.mem_addr", i), mem_addr, tbl[i].x_addr);
      chk($sformatf("vec%0d.cpu_rvalid", i), cpu_rvalid, tbl[i].x_crv);
      chk($sformatf("vec%0d.vga_rvalid", i), vga_rvalid, tbl[i].x_vrv);
      run_cycle($sformatf("vec%0d", i));
    end

    // Reset held two cycles in the middle of a VGA burst.
    v_count = 10'd520; cpu_req = 0; cpu_we = 0; vga_req = 1; vga_addr = 16'h0100;
    run_cycle("rb_enter");
    vga_addr = 16'h0101; run_cycle("rb_g0");
    vga_addr = 16'h0102; run_cycle("rb_g1");
    reset = 1; cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0ABC; cpu_wdata = 16'hBEEF;
    #1;
    chk("rst1.mem_we", mem_we, 1'b0);
    chk("rst1.grant", vga_grant, 1'b0);
    run_cycle("rst1");
    #1;
    chk("rst2.vga_rvalid", vga_rvalid, 1'b0);
    chk("rst2.mem_we", mem_we, 1'b0);
    run_cycle("rst2");
    reset = 0; cpu_req = 0; cpu_we = 0;
    #1;
    chk("post_rst.grant", vga_grant, 1'b0);
    chk("post_rst.mem_we", mem_we, 1'b0);
    chk("post_rst.vga_rvalid", vga_rvalid, 1'b0);
    chk("post_rst.cpu_rvalid", cpu_rvalid, 1'b0);
    chk("post_rst.in_vblank", in_vblank, 1'b0);
    run_cycle("post_rst");
    run_cycle("post_rst2");

    // Random traffic; a stalled CPU request is held unchanged until accepted.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) v_count = 10'($urandom_range(480, 524));
      else v_count = (v_count >= 10'd524) ? 10'd0 : v_count + 10'd1;
      reset = ($urandom_range(0, 199) == 0);
      if (!(cpu_req && m_stall)) begin
        cpu_req   = ($urandom_range(0, 2) != 0);
        cpu_we    = ($urandom_range(0, 2) == 0);
        cpu_addr  = 16'($urandom_range(0, 63));
        cpu_wdata = 16'($urandom);
      end
      vga_req  = ($urandom_range(0, 7) != 0);
      vga_addr = 16'($urandom_range(0, 63));
      run_cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
